pll_lock_sequencer: RTL

Sequences the board's main Gowin rPLL from power-up to a usable logic clock. It runs on the free-running 27 MHz crystal clock and drives the PLL's RESET input. It qualifies the PLL LOCK output and releases a single `ready_o` flag that downstream reset generators use. It retries on lock timeout, reports permanent failure, and detects loss of lock while running.

---
 rtl/pll_lock_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
`timescale 1ns/1ps
// Brings the board rPLL out of reset, qualifies its LOCK output and raises ready_o.
// Define PLL_LOCK_GLITCH_FILTER_EN to debounce lock loss while running.
module pll_lock_sequencer #(
  parameter int RESET_CYCLES        = 32,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lock_i,
  input  logic       restart_i,
  output logic       pll_reset_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic       lock_lost_o,
  output logic [3:0] retry_count_o
);

  localparam int MAX_AB = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_C  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_DONE  = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_DONE = CNT_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] tcnt, tcnt_n;
  logic [3:0]       retry_n, retry_inc, retry_sat;
  logic             pll_reset_n, ready_n, fail_n, lost_n;
  logic             sync_1, lock_s;
  logic             timeout, lose;

`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam logic [1:0] DROP_LAST = 2'd3;
  logic [1:0] drop_cnt, drop_n;
`endif

  // LOCK crosses from the PLL domain through two flops before any decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync_1 <= lock_i;
      lock_s <= sync_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_RESET;
      cnt           <= '0;
      tcnt          <= '0;
      retry_count_o <= '0;
      pll_reset_o   <= 1'b1;
      ready_o       <= 1'b0;
      fail_o        <= 1'b0;
      lock_lost_o   <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      tcnt          <= tcnt_n;
      retry_count_o <= retry_n;
      pll_reset_o   <= pll_reset_n;
      ready_o       <= ready_n;
      fail_o        <= fail_n;
      lock_lost_o   <= lost_n;
    end
  end

`ifdef PLL_LOCK_GLITCH_FILTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else        drop_cnt <= drop_n;
  end
`endif

  assign timeout   = ((state == S_WAIT_LOCK) || (state == S_STABLE)) && (tcnt == TIMEOUT_DONE);
  assign retry_inc = retry_count_o + 4'd1;
  assign retry_sat = (retry_count_o == RETRY_MAX) ? RETRY_MAX : retry_inc;

  // Priority: restart, then timeout, then the per-state lock decisions
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    tcnt_n      = tcnt;
    retry_n     = retry_count_o;
    pll_reset_n = pll_reset_o;
    ready_n     = ready_o;
    fail_n      = fail_o;
    lost_n      = 1'b0;
    lose        = 1'b0;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    drop_n      = '0;
`endif
    if (restart_i) begin
      state_n     = S_RESET;
      cnt_n       = '0;
      retry_n     = '0;
      pll_reset_n = 1'b1;
      ready_n     = 1'b0;
      fail_n      = 1'b0;
    end else if (timeout) begin
      retry_n     = retry_sat;
      cnt_n       = '0;
      pll_reset_n = 1'b1;
      if (retry_inc == RETRY_MAX) begin
        state_n = S_FAIL;
        fail_n  = 1'b1;
      end else begin
        state_n = S_RESET;
      end
    end else begin
      case (state)
        S_RESET: begin
          if (cnt == RESET_LAST) begin
            state_n     = S_WAIT_LOCK;
            cnt_n       = '0;
            tcnt_n      = '0;
            pll_reset_n = 1'b0;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          tcnt_n = tcnt + CNT_ONE;
          if (lock_s) begin
            state_n = S_STABLE;
            cnt_n   = '0;
          end
        end
        S_STABLE: begin
          tcnt_n = tcnt + CNT_ONE;
          if (!lock_s) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == STABLE_DONE) begin
            state_n = S_RUN;
            ready_n = 1'b1;
            retry_n = '0;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        S_RUN: begin
`ifdef PLL_LOCK_GLITCH_FILTER_EN
          if (!lock_s) begin
            if (drop_cnt == DROP_LAST) lose = 1'b1;
            else                       drop_n = drop_cnt + 2'd1;
          end
`else
          lose = !lock_s;
`endif
          if (lose) begin
            state_n     = S_RESET;
            cnt_n       = '0;
            pll_reset_n = 1'b1;
            ready_n     = 1'b0;
            lost_n      = 1'b1;
          end
        end
        default: state_n = state;
      endcase
    end
  end

endmodule
